// File: rtl/mem_arbiter.sv
// Two-port (instruction fetch / data) arbiter onto a single memory port.
// Round-robin on ties, zero-wait completion, lock-in while memory stalls.
module mem_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_req,
    input  logic [31:0]      i_addr,
    output logic             i_done,
    output logic             i_stall,
    output logic             i_err,
    output logic [31:0]      i_rdata,
    input  logic             d_req,
    input  logic             d_wr,
    input  logic [31:0]      d_addr,
    input  logic [31:0]      d_wdata,
    output logic             d_done,
    output logic             d_stall,
    output logic             d_err,
    output logic [31:0]      d_rdata,
    output logic             mem_Rd,
    output logic             mem_Wr,
    output logic [31:0]      mem_Addr,
    output logic [31:0]      mem_DataIn,
    input  logic [31:0]      mem_DataOut,
    input  logic             mem_Done,
    input  logic             mem_Stall,
    input  logic             mem_err,
    output logic [CNT_W-1:0] conflict_cnt
);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    state_t state, state_next;
    logic   last_d, last_d_next;
    logic   sel_i, sel_d;
    logic   gnt_i, gnt_d;
    logic   lose;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        sat_inc = (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // Winner selection: round-robin only when idle, locked while busy.
    always_comb begin
        sel_i = 1'b0;
        sel_d = 1'b0;
        case (state)
            IDLE: begin
                if (i_req && d_req) begin
                    sel_d = !last_d;
                    sel_i = last_d;
                end else begin
                    sel_i = i_req;
                    sel_d = d_req;
                end
            end
            BUSY_I:  sel_i = i_req;
            BUSY_D:  sel_d = d_req;
            default: ;
        endcase
    end

    // Reset gates every combinational output so it drops asynchronously.
    assign gnt_i = rst & sel_i;
    assign gnt_d = rst & sel_d;
    assign lose  = (i_req & ~sel_i) | (d_req & ~sel_d);

    always_comb begin
        state_next  = state;
        last_d_next = last_d;
        case (state)
            IDLE: begin
                if (sel_i || sel_d) begin
                    last_d_next = sel_d;
                    if (!mem_Done) state_next = sel_d ? BUSY_D : BUSY_I;
                end
            end
            BUSY_I:  if (!i_req || mem_Done) state_next = IDLE;
            BUSY_D:  if (!d_req || mem_Done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        mem_Rd     = gnt_i | (gnt_d & ~d_wr);
        mem_Wr     = gnt_d & d_wr;
        mem_Addr   = '0;
        mem_DataIn = '0;
        if (gnt_d) begin
            mem_Addr   = d_addr;
            mem_DataIn = d_wdata;
        end else if (gnt_i) begin
            mem_Addr   = i_addr;
        end
        i_done  = gnt_i & mem_Done;
        d_done  = gnt_d & mem_Done;
        i_err   = i_done & mem_err;
        d_err   = d_done & mem_err;
        i_rdata = i_done ? mem_DataOut : '0;
        d_rdata = d_done ? mem_DataOut : '0;
        i_stall = rst & ((gnt_i & mem_Stall & ~mem_Done) | (i_req & ~sel_i));
        d_stall = rst & ((gnt_d & mem_Stall & ~mem_Done) | (d_req & ~sel_d));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            last_d       <= 1'b0;
            conflict_cnt <= '0;
        end else begin
            state        <= state_next;
            last_d       <= last_d_next;
            conflict_cnt <= lose ? sat_inc(conflict_cnt) : conflict_cnt;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed scenarios then random traffic,
// checked cycle by cycle against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int CW      = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk;
    logic          rst;
    logic          i_req;
    logic [31:0]   i_addr;
    logic          i_done, i_stall, i_err;
    logic [31:0]   i_rdata;
    logic          d_req, d_wr;
    logic [31:0]   d_addr, d_wdata;
    logic          d_done, d_stall, d_err;
    logic [31:0]   d_rdata;
    logic          mem_Rd, mem_Wr;
    logic [31:0]   mem_Addr, mem_DataIn;
    logic [31:0]   mem_DataOut;
    logic          mem_Done, mem_Stall, mem_err;
    logic [CW-1:0] conflict_cnt;

    mem_arbiter #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr),
        .i_done(i_done), .i_stall(i_stall), .i_err(i_err), .i_rdata(i_rdata),
        .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_stall(d_stall), .d_err(d_err), .d_rdata(d_rdata),
        .mem_Rd(mem_Rd), .mem_Wr(mem_Wr), .mem_Addr(mem_Addr), .mem_DataIn(mem_DataIn),
        .mem_DataOut(mem_DataOut), .mem_Done(mem_Done), .mem_Stall(mem_Stall),
        .mem_err(mem_err), .conflict_cnt(conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic          mem_rd;
        logic          mem_wr;
        logic [31:0]   mem_addr;
        logic [31:0]   mem_din;
        logic          i_done;
        logic          i_stall;
        logic          i_err;
        logic [31:0]   i_rdata;
        logic          d_done;
        logic          d_stall;
        logic          d_err;
        logic [31:0]   d_rdata;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t expq[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model state: who owns memory (0 none, 1 fetch, 2 data),
    // whether data won the last arbitration, and the loss count.
    int   owner = 0;
    bit   last_was_d = 0;
    int   cnt_m = 0;
    bit   mdl_i_done, mdl_d_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic apply();
        exp_t e;
        bit   gi, gd;
        e = '0;
        gi = 0;
        gd = 0;
        mdl_i_done = 0;
        mdl_d_done = 0;
        if (!rst) begin
            owner = 0;
            last_was_d = 0;
            cnt_m = 0;
        end else begin
            if (owner == 1)      gi = i_req;
            else if (owner == 2) gd = d_req;
            else if (i_req && d_req) begin
                if (last_was_d) gi = 1; else gd = 1;
            end else begin
                gi = i_req;
                gd = d_req;
            end
            e.mem_rd   = gi || (gd && !d_wr);
            e.mem_wr   = gd && d_wr;
            e.mem_addr = gi ? i_addr : (gd ? d_addr : 32'h0);
            e.mem_din  = gd ? d_wdata : 32'h0;
            e.i_done   = gi && mem_Done;
            e.d_done   = gd && mem_Done;
            e.i_err    = e.i_done && mem_err;
            e.d_err    = e.d_done && mem_err;
            e.i_rdata  = e.i_done ? mem_DataOut : 32'h0;
            e.d_rdata  = e.d_done ? mem_DataOut : 32'h0;
            e.i_stall  = gi ? (mem_Stall && !mem_Done) : i_req;
            e.d_stall  = gd ? (mem_Stall && !mem_Done) : d_req;
            e.cnt      = CW'(cnt_m);
            mdl_i_done = e.i_done;
            mdl_d_done = e.d_done;
            if ((i_req && !gi) || (d_req && !gd))
                cnt_m = (cnt_m + 1 > CNT_MAX) ? CNT_MAX : cnt_m + 1;
            if (gi || gd) begin
                if (owner == 0) last_was_d = gd;
                owner = mem_Done ? 0 : (gi ? 1 : 2);
            end else begin
                owner = 0;
            end
        end
        expq.push_back(e);
    endtask

    task automatic drive(input logic rs, input logic ir, input logic [31:0] ia,
                         input logic dr, input logic dw, input logic [31:0] da,
                         input logic [31:0] dwd, input logic md, input logic me,
                         input logic [31:0] mdo);
        @(posedge clk);
        #1;
        rst = rs; i_req = ir; i_addr = ia;
        d_req = dr; d_wr = dw; d_addr = da; d_wdata = dwd;
        mem_Done = md; mem_Stall = !md; mem_err = me; mem_DataOut = mdo;
        apply();
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            check("mem_Rd",       32'(mem_Rd),       32'(e.mem_rd));
            check("mem_Wr",       32'(mem_Wr),       32'(e.mem_wr));
            check("mem_Addr",     mem_Addr,          e.mem_addr);
            check("mem_DataIn",   mem_DataIn,        e.mem_din);
            check("i_done",       32'(i_done),       32'(e.i_done));
            check("i_stall",      32'(i_stall),      32'(e.i_stall));
            check("i_err",        32'(i_err),        32'(e.i_err));
            check("i_rdata",      i_rdata,           e.i_rdata);
            check("d_done",       32'(d_done),       32'(e.d_done));
            check("d_stall",      32'(d_stall),      32'(e.d_stall));
            check("d_err",        32'(d_err),        32'(e.d_err));
            check("d_rdata",      d_rdata,           e.d_rdata);
            check("conflict_cnt", 32'(conflict_cnt), 32'(e.cnt));
        end
    end

    initial begin
        logic        pi, pd, dwv, md;
        logic [31:0] ia, da, dwd;
        rst = 1'b0; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_wr = 1'b0;
        d_addr = '0; d_wdata = '0; mem_DataOut = '0; mem_Done = 1'b0;
        mem_Stall = 1'b0; mem_err = 1'b0;

        for (int k = 0; k < 3; k++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("reset_cnt", 32'(conflict_cnt), 32'h0);

        // Lone fetch, zero-wait.
        drive(1, 1, 32'h40, 0, 0, 0, 0, 1, 0, 32'h1234_5678);
        #1;
        check("zw_mem_Rd", 32'(mem_Rd), 32'h1);
        check("zw_mem_Addr", mem_Addr, 32'h40);
        check("zw_i_done", 32'(i_done), 32'h1);
        check("zw_i_rdata", i_rdata, 32'h1234_5678);
        drive(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);

        // Tie after reset: data write wins, stalls twice, then fetch follows.
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 32'h200, 1, 1, 32'h100, 32'hDEAD_BEEF, 0, 0, 0);
        #1;
        check("tie_mem_Wr", 32'(mem_Wr), 32'h1);
        check("tie_mem_DataIn", mem_DataIn, 32'hDEAD_BEEF);
        drive(1, 1, 32'h200, 1, 1, 32'h100, 32'hDEAD_BEEF, 0, 0, 0);
        drive(1, 1, 32'h200, 1, 1, 32'h100, 32'hDEAD_BEEF, 1, 0, 0);
        #1;
        check("tie_d_done", 32'(d_done), 32'h1);
        drive(1, 1, 32'h200, 0, 0, 0, 0, 1, 0, 32'h55);
        #1;
        check("tie_cnt", 32'(conflict_cnt), 32'h3);
        check("tie_i_next", mem_Addr, 32'h200);

        // Continuous contention with zero-wait memory.
        for (int k = 0; k < 8; k++) begin
            drive(1, 1, 32'h300, 1, 0, 32'h400, 0, 1, 0, 32'(k));
            #1;
            check("alt_one_done", 32'(i_done) + 32'(d_done), 32'h1);
        end

        // Misaligned data read reports error on data side only.
        drive(1, 0, 0, 1, 0, 32'h102, 0, 1, 1, 32'hA5A5_A5A5);
        #1;
        check("err_d_err", 32'(d_err), 32'h1);
        check("err_d_done", 32'(d_done), 32'h1);
        check("err_i_err", 32'(i_err), 32'h0);

        // Reset in the middle of a stalled fetch.
        drive(1, 1, 32'h500, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 1, 32'h500, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 32'h500, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("rst_i_stall", 32'(i_stall), 32'h0);
        check("rst_mem_Rd", 32'(mem_Rd), 32'h0);
        drive(1, 0, 0, 1, 0, 32'h600, 0, 1, 0, 32'h77);
        #1;
        check("rel_d_done", 32'(d_done), 32'h1);
        check("rel_mem_Addr", mem_Addr, 32'h600);

        // Fetch starved behind a long data stall: counter saturates.
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 21; k++) drive(1, 1, 32'h700, 1, 0, 32'h800, 0, 0, 0, 0);
        #1;
        check("sat_cnt", 32'(conflict_cnt), 32'(CNT_MAX));
        drive(1, 1, 32'h700, 1, 0, 32'h800, 0, 1, 0, 32'h99);
        drive(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);

        // Random traffic with occasional request drops and resets.
        pi = 0; pd = 0; dwv = 0; ia = 0; da = 0; dwd = 0;
        for (int k = 0; k < 600; k++) begin
            if (!pi && $urandom_range(1) == 1) begin pi = 1; ia = $urandom; end
            if (!pd && $urandom_range(1) == 1) begin
                pd = 1; da = $urandom; dwd = $urandom; dwv = 1'($urandom_range(1));
            end
            if (pi && $urandom_range(39) == 0) pi = 0;
            if (pd && $urandom_range(39) == 0) pd = 0;
            md = 1'($urandom_range(1));
            drive(($urandom_range(99) != 0), pi, ia, pd, dwv, da, dwd, md,
                  ($urandom_range(3) == 0), $urandom);
            if (mdl_i_done || !rst) pi = 0;
            if (mdl_d_done || !rst) pd = 0;
        end

        @(negedge clk);
        #1;
        check("queue_drained", 32'(expq.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
